// File: rtl/shift_scheduler.sv
// shift_scheduler: shares one combinational 4-bit shifter between two requesters.
// A request of 0..15 places is broken into passes of at most MAX_STEP places.
// Each pass result is fed back through the shifter until the amount is used up.
//
// Build option:
//   SHIFT_SCHED_FIXED_PRIO_EN  requester 0 always wins arbitration, so requester 1
//                              can starve. When undefined (default), round-robin
//                              arbitration is used with rr_ptr.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for a request; the winner's operand and amount are latched
// GRANT  | one-cycle handoff after the grant; the shifter sees an identity
// PASS   | one shifter pass of min(rem, MAX_STEP) places per cycle
// DONE   | result is valid, done[owner] pulses, and arbitration moves on

module shift_scheduler #(
    parameter int W        = 4,
    parameter int AMT_W    = 4,
    parameter int MAX_STEP = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req0,
    input  logic [W-1:0]       data0,
    input  logic [AMT_W-1:0]   amt0,
    input  logic               req1,
    input  logic [W-1:0]       data1,
    input  logic [AMT_W-1:0]   amt1,
    output logic [W-1:0]       sh_in,
    output logic [MAX_STEP:0]  sh_sel,
    input  logic [W-1:0]       sh_out,
    output logic [W-1:0]       result,
    output logic               done0,
    output logic               done1,
    output logic               busy
);

    localparam int SEL_W = MAX_STEP + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_PASS  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [W-1:0]     work_q, work_d;
    logic [W-1:0]     result_q, result_d;
    logic [AMT_W-1:0] rem_q, rem_d;
    logic             owner_q, owner_d;
    logic [AMT_W-1:0] step;
    logic             winner;
    logic             last_pass;

`ifdef SHIFT_SCHED_FIXED_PRIO_EN
    // Fixed priority: requester 0 wins whenever it is asking.
    always_comb begin
        winner = ~req0;
    end
`else
    logic rr_ptr_q, rr_ptr_d;

    // Round-robin: use rr_ptr only on a tie; otherwise the lone requester wins.
    always_comb begin
        if (req0 && req1) begin
            winner = rr_ptr_q;
        end else begin
            winner = req1;
        end
    end
`endif

    // Size of the current pass. It is also the last pass when the remaining amount fits.
    always_comb begin
        step      = (rem_q > AMT_W'(MAX_STEP)) ? AMT_W'(MAX_STEP) : rem_q;
        last_pass = (rem_q <= AMT_W'(MAX_STEP));
    end

    // Next-state logic and per-state register updates.
    always_comb begin
        state_d  = state_q;
        work_d   = work_q;
        result_d = result_q;
        rem_d    = rem_q;
        owner_d  = owner_q;
`ifndef SHIFT_SCHED_FIXED_PRIO_EN
        rr_ptr_d = rr_ptr_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (req0 || req1) begin
                    owner_d = winner;
                    work_d  = winner ? data1 : data0;
                    rem_d   = winner ? amt1 : amt0;
                    state_d = S_GRANT;
                end
            end
            S_GRANT: begin
                state_d = S_PASS;
            end
            S_PASS: begin
                work_d = sh_out;
                rem_d  = rem_q - step;
                if (last_pass) begin
                    // Load result from the final pass output, which is the value
                    // work takes on at this edge. This keeps result valid for the
                    // whole DONE cycle, alongside the done pulse.
                    result_d = sh_out;
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
`ifndef SHIFT_SCHED_FIXED_PRIO_EN
                rr_ptr_d = ~owner_q;
`endif
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers, with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            work_q   <= '0;
            result_q <= '0;
            rem_q    <= '0;
            owner_q  <= 1'b0;
`ifndef SHIFT_SCHED_FIXED_PRIO_EN
            rr_ptr_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            work_q   <= work_d;
            result_q <= result_d;
            rem_q    <= rem_d;
            owner_q  <= owner_d;
`ifndef SHIFT_SCHED_FIXED_PRIO_EN
            rr_ptr_q <= rr_ptr_d;
`endif
        end
    end

    // Outputs decoded from the registered state. Outside PASS, the shifter sees an identity.
    always_comb begin
        sh_in  = work_q;
        sh_sel = (state_q == S_PASS) ? (SEL_W'(1) << step) : SEL_W'(1);
        result = result_q;
        busy   = (state_q != S_IDLE);
        done0  = (state_q == S_DONE) && !owner_q;
        done1  = (state_q == S_DONE) && owner_q;
    end

endmodule

// File: tb/tb_shift_scheduler.sv
// tb_shift_scheduler: directed tests for shift_scheduler.
// The shifter is modelled as a logical left shift with zero fill.
// An operation-level model predicts every output on every cycle.

module tb_shift_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0, req1;
    logic [3:0] data0, data1, amt0, amt1;
    logic [3:0] sh_in, sh_sel, sh_out, result;
    logic       done0, done1, busy;

    int total = 0;
    int bad   = 0;

    logic [3:0] sel_log [0:31];

    shift_scheduler dut (
        .clk    (clk),
        .rst    (rst),
        .req0   (req0),
        .data0  (data0),
        .amt0   (amt0),
        .req1   (req1),
        .data1  (data1),
        .amt1   (amt1),
        .sh_in  (sh_in),
        .sh_sel (sh_sel),
        .sh_out (sh_out),
        .result (result),
        .done0  (done0),
        .done1  (done1),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    // Shifter model: logical left shift with zero fill.
    always_comb begin
        case (sh_sel)
            4'b0001: sh_out = sh_in;
            4'b0010: sh_out = sh_in << 1;
            4'b0100: sh_out = sh_in << 2;
            4'b1000: sh_out = sh_in << 3;
            default: sh_out = 4'b0000;
        endcase
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] shl(input logic [3:0] d, input int n);
        int t;
        t = int'(d) << n;
        return t[3:0];
    endfunction

    // Operation-level model and per-cycle compare, evaluated at the falling edge.
    bit         m_valid = 0, m_active = 0, m_owner = 0, m_rr = 0;
    int         m_s, m_p, m_amt, cyc = 0;
    logic [3:0] m_data, m_final, m_res, m_work;

    initial begin
        forever begin
            logic [3:0] e_sel, e_in, e_res;
            bit         e_busy, e_d0, e_d1, win;
            int         d, k, rem, st;
            @(negedge clk);
            if (m_valid) begin
                e_busy = 0; e_d0 = 0; e_d1 = 0;
                e_sel = 4'b0001; e_in = m_work; e_res = m_res;
                if (m_active) begin
                    d = cyc - m_s;
                    e_busy = 1;
                    if (d == 1) begin
                        e_in = m_data;
                    end else if (d >= 2 && d <= m_p + 1) begin
                        k     = d - 2;
                        rem   = m_amt - 3 * k;
                        st    = (rem > 3) ? 3 : rem;
                        e_sel = shl(4'b0001, st);
                        e_in  = shl(m_data, 3 * k);
                    end else begin
                        e_d0  = !m_owner;
                        e_d1  = m_owner;
                        e_res = m_final;
                        e_in  = m_final;
                    end
                end
                check("busy",   int'(busy),   int'(e_busy));
                check("done0",  int'(done0),  int'(e_d0));
                check("done1",  int'(done1),  int'(e_d1));
                check("result", int'(result), int'(e_res));
                check("sh_sel", int'(sh_sel), int'(e_sel));
                check("sh_in",  int'(sh_in),  int'(e_in));
            end
            if (rst) begin
                m_valid = 1; m_active = 0; m_rr = 0; m_res = '0; m_work = '0;
            end else if (m_valid) begin
                if (m_active && (cyc - m_s == m_p + 2)) begin
                    m_active = 0;
                    m_res    = m_final;
                    m_work   = m_final;
                    m_rr     = !m_owner;
                end else if (!m_active && (req0 || req1)) begin
`ifdef SHIFT_SCHED_FIXED_PRIO_EN
                    win = !req0;
`else
                    win = (req0 && req1) ? m_rr : req1;
`endif
                    m_active = 1;
                    m_s      = cyc;
                    m_owner  = win;
                    m_data   = win ? data1 : data0;
                    m_amt    = int'(win ? amt1 : amt0);
                    m_p      = (m_amt == 0) ? 1 : (m_amt + 2) / 3;
                    m_final  = shl(m_data, m_amt);
                end
            end
            cyc++;
        end
    end

    // Wait for a done pulse from one requester and record sh_sel on each cycle.
    task automatic wait_done(input bit who, input int max_c, output int lat, output logic [3:0] res);
        lat = -1;
        res = '0;
        for (int i = 1; i <= max_c; i++) begin
            @(posedge clk); #1;
            sel_log[i] = sh_sel;
            if ((!who && done0) || (who && done1)) begin
                lat = i;
                res = result;
                break;
            end
        end
    endtask

    task automatic wait_any(input int max_c, output int who, output logic [3:0] res);
        who = -1;
        res = '0;
        for (int i = 1; i <= max_c; i++) begin
            @(posedge clk); #1;
            if (done0 || done1) begin
                who = done1 ? 1 : 0;
                res = result;
                break;
            end
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int         lat, lat0, lat1, who, dcnt;
        logic [3:0] res, res0, res1;
        int         exp_who [4];
        int         exp_res [4];

        rst = 1; req0 = 0; req1 = 0;
        data0 = '0; data1 = '0; amt0 = '0; amt1 = '0;

        // 1: reset values
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy",   int'(busy),   0);
        check("rst_done0",  int'(done0),  0);
        check("rst_done1",  int'(done1),  0);
        check("rst_result", int'(result), 0);
        check("rst_sh_sel", int'(sh_sel), 1);
        #1 rst = 0;

        // 2: req0 1<<2
        @(posedge clk); #2;
        req0 = 1; data0 = 4'b0001; amt0 = 4'd2;
        wait_done(0, 20, lat, res);
        req0 = 0;
        check("t2_latency", lat, 3);
        check("t2_result",  int'(res), 4);
        check("t2_sel",     int'(sel_log[2]), 4);

        // 3: req1 amt 7, then amt 0
        @(posedge clk); #2;
        req1 = 1; data1 = 4'b0001; amt1 = 4'd7;
        wait_done(1, 20, lat, res);
        req1 = 0;
        check("t3_latency", lat, 5);
        check("t3_result",  int'(res), 0);
        check("t3_sel0",    int'(sel_log[2]), 8);
        check("t3_sel1",    int'(sel_log[3]), 8);
        check("t3_sel2",    int'(sel_log[4]), 2);

        @(posedge clk); #2;
        req1 = 1; data1 = 4'b0001; amt1 = 4'd0;
        wait_done(1, 20, lat, res);
        req1 = 0;
        check("t3z_latency", lat, 3);
        check("t3z_result",  int'(res), 1);
        check("t3z_sel",     int'(sel_log[2]), 1);

        // 4: simultaneous held requests
`ifdef SHIFT_SCHED_FIXED_PRIO_EN
        exp_who = '{0, 0, 0, 0};
        exp_res = '{6, 6, 6, 6};
`else
        exp_who = '{0, 1, 0, 1};
        exp_res = '{6, 4, 6, 4};
`endif
        @(posedge clk); #2;
        req0 = 1; data0 = 4'b0011; amt0 = 4'd1;
        req1 = 1; data1 = 4'b0101; amt1 = 4'd2;
        for (int g = 0; g < 4; g++) begin
            wait_any(20, who, res);
            check($sformatf("t4_grant%0d", g),  who,      exp_who[g]);
            check($sformatf("t4_result%0d", g), int'(res), exp_res[g]);
        end
        req0 = 0; req1 = 0;

        // 5: reset during the second pass of amt 9
        @(posedge clk); #2;
        req0 = 1; data0 = 4'b0001; amt0 = 4'd9;
        repeat (3) begin @(posedge clk); #1; end
        check("t5_busy_mid", int'(busy),   1);
        check("t5_sel_mid",  int'(sh_sel), 8);
        rst = 1; req0 = 0;
        @(posedge clk); #1;
        rst = 0;
        check("t5_busy",   int'(busy),   0);
        check("t5_done0",  int'(done0),  0);
        check("t5_result", int'(result), 0);
        check("t5_sh_sel", int'(sh_sel), 1);
        check("t5_sh_in",  int'(sh_in),  0);
        dcnt = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (done0 || done1) dcnt++;
        end
        check("t5_no_done", dcnt, 0);
        @(posedge clk); #2;
        req0 = 1; data0 = 4'b0011; amt0 = 4'd1;
        wait_done(0, 20, lat, res);
        req0 = 0;
        check("t5_new_latency", lat, 3);
        check("t5_new_result",  int'(res), 6);

        // 6: req0 dropped during GRANT and req1 raised mid-operation
        @(posedge clk); #2;
        req0 = 1; data0 = 4'b0011; amt0 = 4'd2;
        @(posedge clk); #1;
        req0 = 0;
        req1 = 1; data1 = 4'b1001; amt1 = 4'd1;
        lat0 = -1; lat1 = -1; res0 = '0; res1 = '0;
        for (int i = 2; i <= 20; i++) begin
            @(posedge clk); #1;
            if (done0) begin lat0 = i; res0 = result; end
            if (done1) begin lat1 = i; res1 = result; req1 = 0; break; end
        end
        req1 = 0;
        check("t6_done0_at",  lat0, 3);
        check("t6_result0",   int'(res0), 12);
        check("t6_done1_at",  lat1, 7);
        check("t6_result1",   int'(res1), 2);

        repeat (4) @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
